// File: rtl/rc4_stream_xor.sv
// ---------------------------------------------------------------------------
// rc4_stream_xor
//
// Combines an RC4 keystream with a data stream one byte at a time. Keystream
// bytes from the PRGA engine are buffered in a small FIFO so the engine can
// run ahead of the data. Every accepted data byte is XORed with the oldest
// buffered keystream byte and presented one cycle later on a held
// valid/ready output. A message of msg_len bytes ends with a single-cycle
// done pulse.
//
// Parameters
//   FIFO_DEPTH  keystream buffer depth in bytes (power of 2, 2..16)
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   start, msg_len       begin a message of msg_len bytes (sampled in IDLE)
//   ks_valid, ks_data    keystream byte from the PRGA engine
//   ks_ready             keystream byte accepted when ks_valid && ks_ready
//   din_valid, din       plaintext/ciphertext byte
//   din_ready            data byte accepted when din_valid && din_ready
//   dout_valid, dout     result byte (din ^ keystream), held until accepted
//   dout_ready           downstream accepts when dout_valid && dout_ready
//   busy                 high while the message is running
//   byte_cnt             data bytes processed in the current message
//   done                 single-cycle pulse at message end
// ---------------------------------------------------------------------------
module rc4_stream_xor #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] msg_len,
    input  logic       ks_valid,
    input  logic [7:0] ks_data,
    output logic       ks_ready,
    input  logic       din_valid,
    input  logic [7:0] din,
    output logic       din_ready,
    output logic       dout_valid,
    output logic [7:0] dout,
    input  logic       dout_ready,
    output logic       busy,
    output logic [7:0] byte_cnt,
    output logic       done
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_CNT = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t          state;
    logic [7:0]      len_q;     // message length latched at start
    logic [7:0]      ks_cnt;    // keystream bytes accepted this message
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     fifo_cnt;  // occupancy, one bit wider than the pointers
    logic [7:0]      mem [FIFO_DEPTH];

    logic fifo_full;
    logic fifo_empty;
    logic ks_push;
    logic din_pop;

    assign fifo_full  = (fifo_cnt == DEPTH_CNT);
    assign fifo_empty = (fifo_cnt == '0);

    // Both readies depend only on registered state, except that din_ready
    // also looks at dout_ready so a new byte can load in the same cycle the
    // previous result is taken.
    assign ks_ready  = (state == RUN) && !fifo_full && (ks_cnt < len_q);
    assign din_ready = (state == RUN) && !fifo_empty && (byte_cnt < len_q)
                       && (!dout_valid || dout_ready);

    assign ks_push = ks_valid && ks_ready;
    assign din_pop = din_valid && din_ready;

    // NOTE: the keystream storage has no reset; stale entries are never read
    // because the occupancy counter is cleared and pops are gated by empty.
    always_ff @(posedge clk) begin
        if (ks_push) begin
            mem[wr_ptr] <= ks_data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            ks_cnt     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            dout_valid <= 1'b0;
            dout       <= '0;
            busy       <= 1'b0;
            byte_cnt   <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q    <= msg_len;
                        byte_cnt <= '0;
                        ks_cnt   <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        fifo_cnt <= '0;
                        if (msg_len != 8'd0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end

                RUN: begin
                    if (ks_push) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        ks_cnt <= ks_cnt + 8'd1;
                    end

                    if (din_pop) begin
                        dout       <= din ^ mem[rd_ptr];
                        dout_valid <= 1'b1;
                        rd_ptr     <= rd_ptr + AW'(1);
                        byte_cnt   <= byte_cnt + 8'd1;
                    end else if (dout_ready) begin
                        dout_valid <= 1'b0;
                    end

                    // Simultaneous push and pop leaves occupancy unchanged.
                    if (ks_push && !din_pop) begin
                        fifo_cnt <= fifo_cnt + (AW+1)'(1);
                    end else if (din_pop && !ks_push) begin
                        fifo_cnt <= fifo_cnt - (AW+1)'(1);
                    end

                    // Leave only after the last result has been taken.
                    if ((byte_cnt == len_q) && !dout_valid) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                    end
                end

                FINISH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_stream_xor.sv
// ---------------------------------------------------------------------------
// tb_rc4_stream_xor
//
// Self-checking bench for rc4_stream_xor. Stimulus is randomized per
// channel; a behavioural model logs every accepted keystream and data byte
// and derives the required result stream (data[i] ^ keystream[i]) plus the
// handshake rules, and a per-cycle sampler compares the DUT against it.
// Directed messages pin the model with literal expectations.
// ---------------------------------------------------------------------------
module tb_rc4_stream_xor;

    localparam int DEPTH = 4;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       start      = 1'b0;
    logic [7:0] msg_len    = 8'd0;
    logic       ks_valid   = 1'b0;
    logic [7:0] ks_data    = 8'd0;
    logic       ks_ready;
    logic       din_valid  = 1'b0;
    logic [7:0] din        = 8'd0;
    logic       din_ready;
    logic       dout_valid;
    logic [7:0] dout;
    logic       dout_ready = 1'b0;
    logic       busy;
    logic [7:0] byte_cnt;
    logic       done;

    rc4_stream_xor #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .msg_len    (msg_len),
        .ks_valid   (ks_valid),
        .ks_data    (ks_data),
        .ks_ready   (ks_ready),
        .din_valid  (din_valid),
        .din        (din),
        .din_ready  (din_ready),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready),
        .busy       (busy),
        .byte_cnt   (byte_cnt),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: accepted bytes in order, results taken, done pulses seen.
    logic [7:0] ks_log[$];
    logic [7:0] din_log[$];
    logic [7:0] out_log[$];
    int         out_cnt;
    int         done_cnt;
    int         cur_len;
    bit         prev_din;
    bit         prev_stall;
    logic [7:0] prev_dout;
    bit         ks_took;
    bit         din_took;
    bit         expect_stall;
    logic [7:0] stall_exp_g;

    // Offered stimulus for the current message.
    logic [7:0] ks_bytes[$];
    logic [7:0] din_bytes[$];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit coin(input int pv);
        return int'($urandom_range(99, 0)) < pv;
    endfunction

    task automatic model_clear(input int len);
        ks_log.delete();
        din_log.delete();
        out_log.delete();
        out_cnt      = 0;
        done_cnt     = 0;
        cur_len      = len;
        prev_din     = 1'b0;
        prev_stall   = 1'b0;
        ks_took      = 1'b0;
        din_took     = 1'b0;
        expect_stall = 1'b0;
    endtask

    // Per-cycle comparison against the model, run at the falling edge.
    task automatic sample();
        int occ;
        occ = ks_log.size() - din_log.size();

        if (busy || done)
            check("byte_cnt", int'(byte_cnt), din_log.size());

        if (prev_din) begin
            check("latency_valid", int'(dout_valid), 1);
            check("latency_dout", int'(dout),
                  int'(din_log[din_log.size()-1] ^ ks_log[din_log.size()-1]));
        end

        if (prev_stall) begin
            check("hold_valid", int'(dout_valid), 1);
            check("hold_dout", int'(dout), int'(prev_dout));
        end

        if (expect_stall) begin
            check("stall_valid", int'(dout_valid), 1);
            check("stall_dout", int'(dout), int'(stall_exp_g));
            check("stall_din_ready", int'(din_ready), 0);
        end

        if (ks_ready)
            check("ks_ready_allowed",
                  int'((ks_log.size() < cur_len) && (occ < DEPTH)), 1);

        if (din_ready)
            check("din_ready_allowed",
                  int'((occ > 0) && (din_log.size() < cur_len)
                       && (!dout_valid || dout_ready)), 1);

        ks_took  = ks_valid && ks_ready;
        din_took = din_valid && din_ready;

        if (dout_valid && dout_ready) begin
            if (out_cnt < din_log.size())
                check("dout_stream", int'(dout),
                      int'(din_log[out_cnt] ^ ks_log[out_cnt]));
            else
                check("dout_extra", out_cnt, din_log.size());
            out_log.push_back(dout);
            out_cnt++;
        end

        if (ks_took)  ks_log.push_back(ks_data);
        if (din_took) din_log.push_back(din);
        if (done)     done_cnt++;

        prev_din   = din_took;
        prev_stall = dout_valid && !dout_ready;
        prev_dout  = dout;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int len, input int extra);
        ks_bytes.delete();
        din_bytes.delete();
        for (int i = 0; i < len + extra; i++) ks_bytes.push_back(8'($urandom));
        for (int i = 0; i < len; i++)         din_bytes.push_back(8'($urandom));
    endtask

    // Runs one message. din_hold withholds data for that many cycles,
    // stall holds dout_ready low for that many cycles at the first result,
    // abort_at >= 0 returns early after that many data bytes were accepted.
    task automatic run_msg(input int len, input int din_hold, input int stall,
                           input logic [7:0] stall_exp, input int abort_at,
                           input int pv);
        int ki;
        int di;
        int cyc;
        int post;
        int stall_left;
        int nbad;
        ki = 0; di = 0; post = 0; stall_left = stall; nbad = 0;

        model_clear(len);
        start      = 1'b1;
        msg_len    = 8'(len);
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        tick();
        start   = 1'b0;
        msg_len = 8'($urandom);   // must have been latched at start

        for (cyc = 0; cyc < 3000 && post < 3; cyc++) begin
            if (ks_took)  ki++;
            if (din_took) di++;
            if (abort_at >= 0 && di >= abort_at) return;

            if (din_hold > 0 && cyc == din_hold) begin
                check("ks_first_count", ks_log.size(), DEPTH);
                check("ks_first_ready", int'(ks_ready), 0);
            end

            ks_valid  = (ki < ks_bytes.size()) && coin(pv);
            ks_data   = (ki < ks_bytes.size()) ? ks_bytes[ki] : 8'($urandom);
            din_valid = (cyc >= din_hold) && (di < din_bytes.size()) && coin(pv);
            din       = (di < din_bytes.size()) ? din_bytes[di] : 8'($urandom);

            expect_stall = 1'b0;
            if (stall_left > 0 && dout_valid) begin
                dout_ready   = 1'b0;
                expect_stall = 1'b1;
                stall_exp_g  = stall_exp;
                stall_left--;
            end else begin
                dout_ready = coin(pv);
            end

            if (done_cnt > 0) post++;
            tick();
        end

        expect_stall = 1'b0;
        ks_valid     = 1'b0;
        din_valid    = 1'b0;
        dout_ready   = 1'b0;

        check("done_count", done_cnt, 1);
        check("byte_cnt_final", int'(byte_cnt), len);
        check("out_count", out_cnt, len);
        check("ks_accepted", ks_log.size(), len);
        check("busy_after", int'(busy), 0);
        for (int i = 0; i < len; i++)
            if (out_log[i] !== (din_bytes[i] ^ ks_bytes[i])) nbad++;
        check("stream_order", nbad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ks_ready"},   int'(ks_ready),   0);
        check({tag, "_din_ready"},  int'(din_ready),  0);
        check({tag, "_dout_valid"}, int'(dout_valid), 0);
        check({tag, "_dout"},       int'(dout),       0);
        check({tag, "_byte_cnt"},   int'(byte_cnt),   0);
        check({tag, "_done"},       int'(done),       0);
        check({tag, "_busy"},       int'(busy),       0);
    endtask

    logic [7:0] kv_ks  [9] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7};
    logic [7:0] kv_din [9] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] kv_out [9] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    initial begin
        model_clear(0);

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Known vector: "Plaintext" under a fixed keystream.
        ks_bytes.delete();
        din_bytes.delete();
        for (int i = 0; i < 9; i++) begin
            ks_bytes.push_back(kv_ks[i]);
            din_bytes.push_back(kv_din[i]);
        end
        run_msg(9, 0, 0, 8'h00, -1, 100);
        for (int i = 0; i < 9; i++)
            check($sformatf("vector_dout%0d", i), int'(out_log[i]), int'(kv_out[i]));

        // Keystream first: 6 offered back-to-back, data withheld.
        fill_random(6, 0);
        run_msg(6, 12, 0, 8'h00, -1, 100);

        // Backpressure on a first result of 0x33.
        fill_random(4, 0);
        din_bytes[0] = ks_bytes[0] ^ 8'h33;
        run_msg(4, 0, 5, 8'h33, -1, 100);

        // Zero-length message: done two cycles after start, no handshakes.
        model_clear(0);
        start      = 1'b1;
        msg_len    = 8'd0;
        ks_valid   = 1'b1;
        din_valid  = 1'b1;
        dout_ready = 1'b1;
        tick();
        start = 1'b0;
        check("len0_done_c1", int'(done), 0);
        tick();
        check("len0_done_c2", int'(done), 1);
        check("len0_busy", int'(busy), 0);
        tick();
        check("len0_done_c3", int'(done), 0);
        check("len0_ks_hs", ks_log.size(), 0);
        check("len0_din_hs", din_log.size(), 0);
        check("len0_byte_cnt", int'(byte_cnt), 0);
        check("len0_done_count", done_cnt, 1);
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        tick();

        // Randomized messages, with extra keystream offered past msg_len.
        for (int m = 0; m < 8; m++) begin
            int len;
            len = $urandom_range(40, 1);
            fill_random(len, $urandom_range(3, 0));
            run_msg(len, 0, 0, 8'h00, -1, $urandom_range(100, 30));
        end

        // Maximum length.
        fill_random(255, 2);
        run_msg(255, 0, 0, 8'h00, -1, 100);

        // Reset mid-message, then a fresh short message.
        fill_random(8, 0);
        run_msg(8, 0, 0, 8'h00, 3, 70);
        check("abort_no_done", done_cnt, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        ks_valid   = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        model_clear(0);
        @(posedge clk);
        #1;
        tick();
        rst_n = 1'b1;
        tick();
        fill_random(2, 1);
        run_msg(2, 0, 0, 8'h00, -1, 80);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
